ct_lsu_spsram_256x7_ctrl: RTL and testbench

//  Access controller for one 256x7 LSU single-port SRAM. After reset, or on

---
 rtl/ct_lsu_spsram_256x7_ctrl.sv | 96 +++++++++
 tb/tb_ct_lsu_spsram_256x7_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ct_lsu_spsram_256x7_ctrl.sv
// ct_lsu_spsram_256x7_ctrl: init sweep plus write-priority, anti-starvation
// read/write arbiter for one single-port LSU SRAM.
module ct_lsu_spsram_256x7_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 7,
    parameter int STARVE_MAX = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic                  rd_grnt,
    output logic                  rd_data_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bmask,
    output logic                  wr_grnt,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [SW-1:0]         r_starve;
    logic                  r_rd_vld;
    logic                  w_init;
    logic                  w_run;
    logic                  w_wr_grnt;
    logic                  w_rd_grnt;

    // Outputs are held at their idle values while reset is asserted.
    assign w_init    = (r_state == S_INIT) && !cpurst;
    assign w_run     = (r_state == S_RUN) && !cpurst;
    assign w_wr_grnt = w_run && wr_req && !(rd_req && r_starve == SW'(STARVE_MAX));
    assign w_rd_grnt = w_run && rd_req && !w_wr_grnt;

    assign init_done   = w_run;
    assign rd_grnt     = w_rd_grnt;
    assign wr_grnt     = w_wr_grnt;
    assign rd_data_vld = r_rd_vld;
    assign rd_data     = sram_q;

    always_comb begin
        w_state_nxt = r_state;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        sram_a      = r_cnt;
        sram_d      = INIT_VAL;
        if (w_init) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            if (&r_cnt) w_state_nxt = S_RUN;
        end else if (w_wr_grnt) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_bmask;
            sram_a    = wr_idx;
            sram_d    = wr_data;
        end else if (w_rd_grnt) begin
            sram_cen = 1'b0;
            sram_a   = rd_idx;
        end
        if (w_run && init_req) w_state_nxt = S_INIT;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state  <= S_INIT;
            r_cnt    <= '0;
            r_starve <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_init ? r_cnt + 1'b1 : '0;
            // Count only writes that overtake a waiting read; any read grant or idle read side clears it.
            r_starve <= (!rd_req || w_rd_grnt) ? '0 :
                        (w_wr_grnt && r_starve != SW'(STARVE_MAX)) ? r_starve + 1'b1 : r_starve;
            r_rd_vld <= w_rd_grnt;
        end
    end
endmodule

// File: tb/tb_ct_lsu_spsram_256x7_ctrl.sv
// tb_ct_lsu_spsram_256x7_ctrl: vector table, directed corner sequences and
// random traffic against a memory/arbitration reference model.
module tb_ct_lsu_spsram_256x7_ctrl;
    logic       clk = 1'b0;
    logic       cpurst = 1'b1;
    logic       init_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] rd_idx = '0;
    logic [7:0] wr_idx = '0;
    logic [6:0] wr_data = '0;
    logic [6:0] wr_bmask = '0;
    logic       init_done, rd_grnt, rd_data_vld, wr_grnt, sram_cen, sram_gwen;
    logic [6:0] rd_data, sram_wen, sram_d;
    logic [6:0] sram_q = '0;
    logic [7:0] sram_a;
    logic [6:0] mem [256];
    logic [6:0] ref_mem [256];
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic       rr, wr;
        logic [7:0] ri, wi;
        logic [6:0] wd, wm;
        logic       er, ew, ecen, egwen;
        logic [6:0] ewen;
        logic [7:0] ea;
    } vec_t;
    vec_t vt [7];

    ct_lsu_spsram_256x7_ctrl dut (
        .forever_cpuclk(clk), .cpurst(cpurst), .init_req(init_req), .init_done(init_done),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_grnt(rd_grnt), .rd_data_vld(rd_data_vld),
        .rd_data(rd_data), .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_bmask(wr_bmask), .wr_grnt(wr_grnt), .sram_a(sram_a), .sram_cen(sram_cen),
        .sram_gwen(sram_gwen), .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM with active-low bit write enables.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_wr(input logic [7:0] i, input logic [6:0] d, input logic [6:0] m);
        ref_mem[i] = (ref_mem[i] & ~m) | (d & m);
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("init_wr", {rd_grnt, wr_grnt, init_done, sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
                {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 8'(i), 7'h00});
            tick;
        end
        if (n == 256) for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    task automatic do_write(input logic [7:0] i, input logic [6:0] d, input logic [6:0] m);
        wr_req = 1'b1; wr_idx = i; wr_data = d; wr_bmask = m;
        #1;
        for (int k = 0; k < 300 && !wr_grnt; k++) begin tick; #1; end
        chk("wr_grnt", wr_grnt, 1'b1);
        chk("wr_port", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {1'b0, 1'b0, 7'(~m), i, d});
        ref_wr(i, d, m);
        tick;
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] i);
        logic [6:0] e;
        rd_req = 1'b1; rd_idx = i;
        #1;
        for (int k = 0; k < 300 && !rd_grnt; k++) begin tick; #1; end
        chk("rd_grnt", rd_grnt, 1'b1);
        chk("rd_port", {sram_cen, sram_gwen, sram_wen, sram_a}, {1'b0, 1'b1, 7'h7F, i});
        chk("rd_vld_early", rd_data_vld, 1'b0);
        e = ref_mem[i];
        tick;
        rd_req = 1'b0;
        #1;
        chk("rd_vld", rd_data_vld, 1'b1);
        chk("rd_data", rd_data, e);
        tick;
    endtask

    initial begin
        logic       rq, wq, ew, er, ev;
        logic [7:0] ri, wi;
        logic [6:0] wd, wm, ed;
        int         wwin;
        for (int i = 0; i < 256; i++) mem[i] = 7'h33;
        vt[0] = '{1'b0, 1'b0, 8'd0,  8'd0,  7'h00, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 7'h7F, 8'd0};
        vt[1] = '{1'b0, 1'b1, 8'd0,  8'd10, 7'h11, 7'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 8'd10};
        vt[2] = '{1'b1, 1'b0, 8'd20, 8'd0,  7'h00, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 7'h7F, 8'd20};
        vt[3] = '{1'b1, 1'b1, 8'd3,  8'd4,  7'h66, 7'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 7'h70, 8'd4};
        vt[4] = '{1'b1, 1'b0, 8'd7,  8'd0,  7'h00, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 7'h7F, 8'd7};
        vt[5] = '{1'b0, 1'b1, 8'd0,  8'd9,  7'h7F, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h7F, 8'd9};
        vt[6] = '{1'b0, 1'b0, 8'd0,  8'd0,  7'h00, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 7'h7F, 8'd0};

        @(negedge clk);
        #1;
        chk("reset_out", {init_done, rd_grnt, wr_grnt, rd_data_vld, sram_cen, sram_gwen, sram_wen},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'h7F});
        tick;
        cpurst = 1'b0;
        sweep(256);
        #1;
        chk("init_done_257", init_done, 1'b1);
        tick;
        do_read(8'd0);
        do_read(8'd128);
        do_read(8'd255);

        foreach (vt[v]) begin
            rd_req = vt[v].rr; wr_req = vt[v].wr; rd_idx = vt[v].ri;
            wr_idx = vt[v].wi; wr_data = vt[v].wd; wr_bmask = vt[v].wm;
            #1;
            chk($sformatf("vec%0d_grnt", v), {rd_grnt, wr_grnt}, {vt[v].er, vt[v].ew});
            chk($sformatf("vec%0d_ctl", v), {sram_cen, sram_gwen, sram_wen}, {vt[v].ecen, vt[v].egwen, vt[v].ewen});
            if (!vt[v].ecen) chk($sformatf("vec%0d_a", v), sram_a, vt[v].ea);
            if (vt[v].ew) begin
                chk($sformatf("vec%0d_d", v), sram_d, vt[v].wd);
                ref_wr(vt[v].wi, vt[v].wd, vt[v].wm);
            end
            tick;
        end
        rd_req = 1'b0; wr_req = 1'b0;
        tick;

        do_write(8'd5, 7'h55, 7'h7F);
        do_read(8'd5);
        do_write(8'd5, 7'h2A, 7'h0F);
        do_read(8'd5);
        chk("merge_5A", ref_mem[5], 7'h5A);

        // Continuous contention: four writes then a forced read, repeating.
        rd_req = 1'b1; rd_idx = 8'd5; wr_req = 1'b1; wr_idx = 8'd6; wr_data = 7'h19; wr_bmask = 7'h7F;
        for (int k = 0; k < 15; k++) begin
            #1;
            chk($sformatf("starve_k%0d", k), {rd_grnt, wr_grnt}, {k % 5 == 4, k % 5 != 4});
            if (k > 0 && k % 5 == 0) chk("starve_rd_data", {rd_data_vld, rd_data}, {1'b1, 7'h5A});
            if (wr_grnt) ref_wr(8'd6, 7'h19, 7'h7F);
            tick;
        end
        rd_req = 1'b0; wr_req = 1'b0;
        tick;

        // init_req in RUN: same-cycle write still granted, pending read stalls for the sweep.
        init_req = 1'b1; wr_req = 1'b1; wr_idx = 8'd33; wr_data = 7'h7F; wr_bmask = 7'h7F;
        #1;
        chk("initreq_wr_grnt", {wr_grnt, init_done}, {1'b1, 1'b1});
        tick;
        init_req = 1'b0; wr_req = 1'b0; rd_req = 1'b1; rd_idx = 8'd33;
        for (int i = 0; i < 256; i++) begin
            #1;
            chk("reinit_stall", {rd_grnt, wr_grnt, init_done, sram_cen, sram_gwen, sram_a}, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i)});
            tick;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        #1;
        chk("reinit_rd_first", {rd_grnt, init_done, sram_a}, {1'b1, 1'b1, 8'd33});
        tick;
        rd_req = 1'b0;
        #1;
        chk("reinit_rd_data", {rd_data_vld, rd_data}, {1'b1, 7'h00});
        tick;

        // Reset in the middle of a sweep restarts it at entry 0.
        cpurst = 1'b1;
        #1;
        chk("rst_run_idle", {sram_cen, init_done}, {1'b1, 1'b0});
        tick;
        cpurst = 1'b0;
        sweep(100);
        cpurst = 1'b1;
        #1;
        chk("rst_mid_sweep", {sram_cen, sram_gwen, sram_wen}, {1'b1, 1'b1, 7'h7F});
        tick;
        cpurst = 1'b0;
        sweep(256);
        #1;
        chk("init_done_after_rst", init_done, 1'b1);
        tick;

        rq = 1'b0; wq = 1'b0; ri = '0; wi = '0; wd = '0; wm = '0; ev = 1'b0; ed = '0; wwin = 0;
        for (int c = 0; c < 600; c++) begin
            if (!rq) begin rq = ($urandom_range(0, 2) != 0); ri = 8'($urandom_range(0, 15)); end
            if (!wq) begin
                wq = ($urandom_range(0, 3) != 0); wi = 8'($urandom_range(0, 15));
                wd = 7'($urandom); wm = 7'($urandom);
            end
            rd_req = rq; rd_idx = ri; wr_req = wq; wr_idx = wi; wr_data = wd; wr_bmask = wm;
            #1;
            ew = wq && !(rq && wwin == 4);
            er = rq && !ew;
            chk("rnd_grnt", {rd_grnt, wr_grnt}, {er, ew});
            chk("rnd_dual", rd_grnt && wr_grnt, 1'b0);
            chk("rnd_cen", sram_cen, !(rd_grnt || wr_grnt));
            if (ew) chk("rnd_wr_port", {sram_gwen, sram_a, sram_wen, sram_d}, {1'b0, wi, 7'(~wm), wd});
            if (er) chk("rnd_rd_port", {sram_gwen, sram_a}, {1'b1, ri});
            chk("rnd_vld", rd_data_vld, ev);
            if (ev) chk("rnd_rd_data", rd_data, ed);
            ev = er;
            if (er) ed = ref_mem[ri];
            if (ew) ref_wr(wi, wd, wm);
            wwin = (!rq || er) ? 0 : (ew && wwin < 4) ? wwin + 1 : wwin;
            if (er) rq = 1'b0;
            if (ew) wq = 1'b0;
            tick;
        end
        rd_req = 1'b0; wr_req = 1'b0;
        #1;
        chk("rnd_last_vld", rd_data_vld, ev);
        if (ev) chk("rnd_last_data", rd_data, ed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
